// File: rtl/dip_frame_ctrl.sv
// dip_frame_ctrl: frame sequencer gating camera pixels into a 3x3 DIP pipeline
// Ports: clk/rst_n; run, vsync, pix_valid, pix_data, cfg_mode, cfg_thresh in;
// dip_en/dip_data to window generator, pipe_clr, frame-stable mode_q/thresh_q,
// busy, frame_done/frame_err pulses, frame_cnt completed-frame counter.
module dip_frame_ctrl #(
  parameter int IMG_W     = 1024,
  parameter int IMG_H     = 768,
  parameter int DRAIN_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        vsync,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_thresh,
  output logic        dip_en,
  output logic [7:0]  dip_data,
  output logic        pipe_clr,
  output logic [1:0]  mode_q,
  output logic [7:0]  thresh_q,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [7:0]    DC_LOAD  = 8'(DRAIN_CYC - 1);
  typedef enum logic [2:0] {IDLE, ARM, ACTIVE, DRAIN, DONE} state_t;
  state_t state;
  logic vsync_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] dcnt;
  logic vs_rise;
  logic last_pix;
  assign vs_rise  = vsync & ~vsync_d;
  assign last_pix = pix_valid && col == COL_LAST && row == ROW_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsync_d    <= 1'b0;
      col        <= '0;
      row        <= '0;
      dcnt       <= '0;
      dip_en     <= 1'b0;
      dip_data   <= '0;
      pipe_clr   <= 1'b0;
      mode_q     <= '0;
      thresh_q   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_d    <= vsync;
      dip_en     <= 1'b0;
      pipe_clr   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: state <= run ? ARM : IDLE;
        ARM: begin
          if (vs_rise) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            pipe_clr <= 1'b1;
            mode_q   <= cfg_mode;
            thresh_q <= cfg_thresh;
            col      <= '0;
            row      <= '0;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          // a new frame start wins over any pixel in the same cycle
          if (vs_rise) begin
            frame_err <= 1'b1;
            pipe_clr  <= 1'b1;
            mode_q    <= cfg_mode;
            thresh_q  <= cfg_thresh;
            col       <= '0;
            row       <= '0;
          end else if (pix_valid) begin
            dip_en   <= 1'b1;
            dip_data <= pix_data;
            if (last_pix) begin
              state <= DRAIN;
              dcnt  <= DC_LOAD;
              col   <= '0;
              row   <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == 8'd0) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            dcnt <= dcnt - 8'd1;
          end
        end
        DONE: state <= run ? ARM : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dip_frame_ctrl.sv
// tb_dip_frame_ctrl: directed self-checking bench for dip_frame_ctrl (4x3 frame, 2 drain cycles)
module tb_dip_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic vsync = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_thresh = '0;
  logic dip_en;
  logic [7:0] dip_data;
  logic pipe_clr;
  logic [1:0] mode_q;
  logic [7:0] thresh_q;
  logic busy;
  logic frame_done;
  logic frame_err;
  logic [15:0] frame_cnt;
  int total = 0;
  int bad = 0;
  dip_frame_ctrl #(.IMG_W(4), .IMG_H(3), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .vsync(vsync), .pix_valid(pix_valid),
    .pix_data(pix_data), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .dip_en(dip_en), .dip_data(dip_data), .pipe_clr(pipe_clr), .mode_q(mode_q),
    .thresh_q(thresh_q), .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_frame;
    vsync = 1'b0;
    tick;
    chk("arm_busy", 16'(busy), 16'd0);
    chk("arm_en", 16'(dip_en), 16'd0);
    vsync = 1'b1;
    tick;
    chk("start_clr", 16'(pipe_clr), 16'd1);
    chk("start_busy", 16'(busy), 16'd1);
    vsync = 1'b0;
  endtask
  task automatic feed(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data = base + 8'(i);
      tick;
      chk("pix_en", 16'(dip_en), 16'd1);
      chk("pix_data", 16'(dip_data), 16'(base + 8'(i)));
    end
    pix_valid = 1'b0;
  endtask
  task automatic drain_done(input logic [15:0] cnt);
    pix_valid = 1'b0;
    tick;
    chk("drain_en", 16'(dip_en), 16'd0);
    chk("drain_busy", 16'(busy), 16'd1);
    chk("drain_done", 16'(frame_done), 16'd0);
    tick;
    chk("done_pulse", 16'(frame_done), 16'd1);
    chk("done_busy", 16'(busy), 16'd0);
    chk("done_cnt", frame_cnt, cnt);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_en", 16'(dip_en), 16'd0);
    chk("rst_data", 16'(dip_data), 16'd0);
    chk("rst_clr", 16'(pipe_clr), 16'd0);
    chk("rst_mode", 16'(mode_q), 16'd0);
    chk("rst_thresh", 16'(thresh_q), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(frame_done), 16'd0);
    chk("rst_err", 16'(frame_err), 16'd0);
    chk("rst_cnt", frame_cnt, 16'd0);
    rst_n = 1'b1;
    tick;
    // basic frame
    run = 1'b1;
    cfg_mode = 2'd1;
    cfg_thresh = 8'h55;
    start_frame;
    chk("f1_mode", 16'(mode_q), 16'd1);
    chk("f1_thresh", 16'(thresh_q), 16'h55);
    feed(12, 8'd0);
    drain_done(16'd1);
    // cfg stability within a frame
    start_frame;
    chk("f2_mode0", 16'(mode_q), 16'd1);
    feed(6, 8'h10);
    cfg_mode = 2'd3;
    cfg_thresh = 8'h99;
    feed(6, 8'h16);
    chk("f2_mode1", 16'(mode_q), 16'd1);
    chk("f2_thresh", 16'(thresh_q), 16'h55);
    drain_done(16'd2);
    start_frame;
    chk("f3_mode", 16'(mode_q), 16'd3);
    chk("f3_thresh", 16'(thresh_q), 16'h99);
    // abort after 7 pixels; coincident pixel dropped
    feed(7, 8'h40);
    cfg_mode = 2'd2;
    vsync = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hAA;
    tick;
    chk("abort_err", 16'(frame_err), 16'd1);
    chk("abort_clr", 16'(pipe_clr), 16'd1);
    chk("abort_en", 16'(dip_en), 16'd0);
    chk("abort_hold", 16'(dip_data), 16'h46);
    chk("abort_busy", 16'(busy), 16'd1);
    chk("abort_mode", 16'(mode_q), 16'd2);
    chk("abort_cnt", frame_cnt, 16'd2);
    vsync = 1'b0;
    feed(12, 8'h20);
    chk("post_abort_err", 16'(frame_err), 16'd0);
    drain_done(16'd3);
    // run dropped mid-frame
    start_frame;
    feed(6, 8'h60);
    run = 1'b0;
    feed(6, 8'h66);
    drain_done(16'd4);
    tick;
    chk("idle_busy", 16'(busy), 16'd0);
    vsync = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_en", 16'(dip_en), 16'd0);
      chk("idle_clr", 16'(pipe_clr), 16'd0);
      chk("idle_busy2", 16'(busy), 16'd0);
    end
    pix_valid = 1'b0;
    // pixels and vs_rise during drain
    run = 1'b1;
    start_frame;
    feed(12, 8'h80);
    pix_valid = 1'b1;
    pix_data = 8'h77;
    vsync = 1'b1;
    tick;
    chk("dr_en0", 16'(dip_en), 16'd0);
    chk("dr_done0", 16'(frame_done), 16'd0);
    chk("dr_err0", 16'(frame_err), 16'd0);
    tick;
    chk("dr_en1", 16'(dip_en), 16'd0);
    chk("dr_done1", 16'(frame_done), 16'd1);
    chk("dr_cnt", frame_cnt, 16'd5);
    pix_valid = 1'b0;
    tick;
    chk("dr_done2", 16'(frame_done), 16'd0);
    chk("dr_en2", 16'(dip_en), 16'd0);
    // asynchronous reset mid-frame
    start_frame;
    feed(7, 8'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 16'(dip_en), 16'd0);
    chk("arst_data", 16'(dip_data), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_cnt", frame_cnt, 16'd0);
    chk("arst_mode", 16'(mode_q), 16'd0);
    chk("arst_thresh", 16'(thresh_q), 16'd0);
    chk("arst_clr", 16'(pipe_clr), 16'd0);
    chk("arst_err", 16'(frame_err), 16'd0);
    tick;
    rst_n = 1'b1;
    start_frame;
    chk("rel_err", 16'(frame_err), 16'd0);
    feed(12, 8'hE0);
    drain_done(16'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
